dreg_univ_shift: RTL and testbench
==================================

// Module: dreg_univ_shift
// PURPOSE
//  Parametrised WIDTH-bit D-register bank with synchronous clear/preset, parallel load and
//  left/right shift/rotate. Adds a counted shift-burst engine (start/busy/done).
//  Storage/shift element for the lab's serial-parallel and counter experiments.
// PARAMETERS
//  WIDTH      4    register width in bits (>=2)
//  CNT_W      3    width of shift_cnt; burst length 0..2**CNT_W-1
//  RESET_VAL  0    value loaded into q_out by clr (WIDTH bits)
// PORTS
//  clk        in   1      rising-edge clock
//  clr        in   1      synchronous reset, active-high
//  preset     in   1      synchronous preset, active-high: q_out <= all ones
//  en         in   1      clock enable for mode ops and burst steps
//  mode       in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load
//  rot        in   1      1: shifts rotate, 0: shifts take serial input
//  sin_r      in   1      serial in at MSB on right shift
//  sin_l      in   1      serial in at LSB on left shift
//  d_in       in   WIDTH  parallel load data
//  start      in   1      begin counted burst (mode 01/10 only)
//  shift_cnt  in   CNT_W  number of shifts in burst
//  q_out      out  WIDTH  register contents
//  q_bar      out  WIDTH  ~q_out (combinational)
//  sout_r     out  1      q_out[0] (combinational)
//  sout_l     out  1      q_out[WIDTH-1] (combinational)
//  busy       out  1      high while burst in progress
//  done       out  1      one-cycle pulse at burst completion
// BEHAVIOUR
//  - Reset (clr=1 at edge): q_out=RESET_VAL, busy=0, done=0, remaining count=0, FSM->IDLE.
//  - Priority at each edge: clr > preset > start/FSM > mode op. Preset: q_out=all ones,
//    busy=0, done=0, FSM->IDLE (aborts any burst, no done).
//  - Shift right: q <= {rot?q[0]:sin_r, q[WIDTH-1:1]}; shift left: q <= {q[WIDTH-2:0], rot?q[WIDTH-1]:sin_l}.
//  - FSM states IDLE, SHIFT, DONE:
//    IDLE: en=1 -> apply mode op, 1-cycle latency. start=1 with mode 01/10 (en ignored for
//      acceptance) -> latch direction, rot and shift_cnt; cnt>0 -> SHIFT, busy=1; cnt=0 -> DONE.
//      start with mode 00/11 ignored (mode op executes normally if en=1). Start edge performs no shift.
//    SHIFT: each edge with en=1 performs one shift in latched direction, decrements count;
//      en=0 stalls (q, count held, busy stays 1). Last shift -> DONE, busy=0.
//      mode, d_in, start, live rot ignored; sin_r/sin_l sampled live each step.
//    DONE: done=1 for exactly one cycle, q held, -> IDLE. start here is ignored.
//  - busy and done never both 1. Count never underflows.
//  - All outputs registered except q_bar, sout_r, sout_l.
// STRUCTURE
//  - Shared package dreg_pkg: mode encodings (MODE_HOLD/SHR/SHL/LOAD), FSM state
//    localparams (ST_IDLE/ST_SHIFT/ST_DONE).
//  - Sub-module usr_step: combinational next-value function (q, dir, rot, sin_r, sin_l,
//    d_in, op) -> q_next; reused by the mode path and the burst path.
// TESTING  (WIDTH=4, CNT_W=3, RESET_VAL=0)
//  1 clr=1 with q=1111 mid-burst -> next edge q=0000, q_bar=1111, busy=0, done=0.
//  2 en=1 mode=11 d_in=1010 -> q=1010 after 1 edge; mode=00 for 3 edges -> q stays 1010.
//  3 q=1011, mode=01 rot=0 sin_r=0 -> 0101, sout_r then 1; repeat from 1011 with rot=1 -> 1101.
//  4 q=0001, start, mode=10, cnt=3, rot=0, sin_l=0 -> busy 3 cycles, q 0010/0100/1000, then done 1 cycle.
//  5 burst as 4 with en=0 for 2 cycles after first shift -> q holds 0010, busy stays 1, total busy 5;
//    separate run: preset during SHIFT -> q=1111, busy=0, no done pulse.
//  6 start with cnt=0, mode=01 -> q unchanged, busy never 1, done pulses one cycle after start edge.

Source files
------------

// File: rtl/dreg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dreg_pkg
//  Description : Shared encodings for the universal shift register bank:
//                operation modes and burst-engine FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package dreg_pkg;

    // Operation modes presented on the mode port
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Burst engine states
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // True for the two modes a burst may be started with
    function automatic logic is_shift_mode(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/usr_step.sv
`default_nettype none
// ============================================================================
//  Module      : usr_step
//  Description : Combinational next-value function of the register bank.
//                One step of hold / shift right / shift left / load.
//  Revision    : 1.0  initial release
// ============================================================================
module usr_step
    import dreg_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       op,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] q_next
);

    // Rotation feeds the bit falling off the far end back in; otherwise serial input
    always_comb begin
        q_next = q;
        case (op)
            MODE_SHR:  q_next = {(rot ? q[0] : sin_r), q[WIDTH-1:1]};
            MODE_SHL:  q_next = {q[WIDTH-2:0], (rot ? q[WIDTH-1] : sin_l)};
            MODE_LOAD: q_next = d_in;
            default:   q_next = q;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dreg_univ_shift.sv
`default_nettype none
// ============================================================================
//  Module      : dreg_univ_shift
//  Description : WIDTH-bit universal shift register with synchronous clear and
//                preset, parallel load, shift/rotate, and a counted shift
//                burst engine (start / busy / done).
//  Revision    : 1.0  initial release
// ============================================================================
module dreg_univ_shift
    import dreg_pkg::*;
#(
    parameter int               WIDTH     = 4,
    parameter int               CNT_W     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             preset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             rot,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic [CNT_W-1:0] shift_cnt,
    output logic [WIDTH-1:0] q_out,
    output logic [WIDTH-1:0] q_bar,
    output logic             sout_r,
    output logic             sout_l,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_dir_op;
    logic             r_rot;

    logic [WIDTH-1:0] w_q_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       w_dir_op_next;
    logic             w_rot_next;
    logic             w_start_ok;
    logic             w_last_step;

    logic [1:0]       w_step_op;
    logic             w_step_rot;
    logic [WIDTH-1:0] w_step_q;

    assign w_start_ok  = start && is_shift_mode(mode);
    assign w_last_step = en && (r_cnt <= c_CNT_ONE);

    // During a burst the step function uses the latched direction and rot;
    // serial inputs stay live in both paths
    assign w_step_op  = (r_state == ST_SHIFT) ? r_dir_op : mode;
    assign w_step_rot = (r_state == ST_SHIFT) ? r_rot    : rot;

    usr_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q      (r_q),
        .op     (w_step_op),
        .rot    (w_step_rot),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .d_in   (d_in),
        .q_next (w_step_q)
    );

    // State register: clear and preset both return the engine to idle
    always_ff @(posedge clk) begin
        if (clr || preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = (shift_cnt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last_step) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values; start edge and done cycle never move q
    always_comb begin
        w_q_next      = r_q;
        w_busy_next   = 1'b0;
        w_done_next   = 1'b0;
        w_cnt_next    = r_cnt;
        w_dir_op_next = r_dir_op;
        w_rot_next    = r_rot;
        case (r_state)
            ST_IDLE: begin
                if (w_start_ok) begin
                    w_dir_op_next = mode;
                    w_rot_next    = rot;
                    w_cnt_next    = shift_cnt;
                    w_busy_next   = (shift_cnt != '0);
                    w_done_next   = (shift_cnt == '0);
                end else if (en) begin
                    w_q_next = w_step_q;
                end
            end
            ST_SHIFT: begin
                w_busy_next = 1'b1;
                if (en) begin
                    w_q_next = w_step_q;
                    if (r_cnt != '0) begin
                        w_cnt_next = r_cnt - c_CNT_ONE;
                    end
                    if (w_last_step) begin
                        w_busy_next = 1'b0;
                        w_done_next = 1'b1;
                    end
                end
            end
            default: begin
                w_q_next = r_q;
            end
        endcase
    end

    // Registered outputs and burst context with clear > preset priority
    always_ff @(posedge clk) begin
        if (clr) begin
            r_q      <= RESET_VAL;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
            r_dir_op <= MODE_HOLD;
            r_rot    <= 1'b0;
        end else if (preset) begin
            r_q      <= '1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_q      <= w_q_next;
            r_busy   <= w_busy_next;
            r_done   <= w_done_next;
            r_cnt    <= w_cnt_next;
            r_dir_op <= w_dir_op_next;
            r_rot    <= w_rot_next;
        end
    end

    assign q_out  = r_q;
    assign q_bar  = ~r_q;
    assign sout_r = r_q[0];
    assign sout_l = r_q[WIDTH-1];
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dreg_univ_shift.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dreg_univ_shift
//  Description : Self-checking bench for dreg_univ_shift (WIDTH=4, CNT_W=3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dreg_univ_shift;

    logic       clk = 1'b0;
    logic       clr = 1'b0, preset = 1'b0, en = 1'b0, rot = 1'b0;
    logic       sin_r = 1'b0, sin_l = 1'b0, start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] d_in = 4'h0;
    logic [2:0] shift_cnt = 3'd0;
    logic [3:0] q_out, q_bar;
    logic       sout_r, sout_l, busy, done;

    int cmp = 0;
    int err = 0;

    // Reference model: register value plus "shifts still owed" bookkeeping
    int m_q = 0;
    int m_owed = 0;
    bit m_bursting = 0;
    bit m_done = 0;
    bit m_left = 0;
    bit m_rot = 0;

    dreg_univ_shift #(.WIDTH(4), .CNT_W(3), .RESET_VAL(4'h0)) dut (
        .clk(clk), .clr(clr), .preset(preset), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d_in(d_in), .start(start),
        .shift_cnt(shift_cnt), .q_out(q_out), .q_bar(q_bar), .sout_r(sout_r),
        .sout_l(sout_l), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic int shr(int q, bit r, bit s);
        return (q / 2) + ((r ? (q % 2) : int'(s)) * 8);
    endfunction

    function automatic int shl(int q, bit r, bit s);
        return ((q * 2) % 16) + (r ? (q / 8) : int'(s));
    endfunction

    // Advance the model on the current inputs, then clock the DUT
    task automatic tick();
        bit was_done;
        was_done = m_done;
        m_done = 0;
        if (clr) begin
            m_q = 0; m_owed = 0; m_bursting = 0;
        end else if (preset) begin
            m_q = 15; m_owed = 0; m_bursting = 0;
        end else if (was_done) begin
            // completion cycle: register frozen
        end else if (m_bursting) begin
            if (en) begin
                m_q = m_left ? shl(m_q, m_rot, sin_l) : shr(m_q, m_rot, sin_r);
                m_owed = m_owed - 1;
                if (m_owed == 0) begin m_bursting = 0; m_done = 1; end
            end
        end else if (start && (mode == 2'b01 || mode == 2'b10)) begin
            m_left = (mode == 2'b10); m_rot = rot; m_owed = int'(shift_cnt);
            if (m_owed > 0) m_bursting = 1; else m_done = 1;
        end else if (en) begin
            if (mode == 2'b01) m_q = shr(m_q, rot, sin_r);
            else if (mode == 2'b10) m_q = shl(m_q, rot, sin_l);
            else if (mode == 2'b11) m_q = int'(d_in);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] v);
        start = 0; en = 1; mode = 2'b11; d_in = v;
        tick();
        mode = 2'b00;
    endtask

    task automatic test_reset();
        clr = 1; tick(); clr = 0;
        preset = 1; tick(); preset = 0;
        en = 1; rot = 1; mode = 2'b10; shift_cnt = 3'd5; start = 1;
        tick(); start = 0;
        tick();
        cmp++; if (busy !== 1'b1) begin err++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
        clr = 1; tick(); clr = 0; rot = 0; mode = 2'b00;
        cmp++; if (q_out !== 4'b0000) begin err++; $display("FAIL rst_q got=%b exp=0000", q_out); end
        cmp++; if (q_bar !== 4'b1111) begin err++; $display("FAIL rst_qbar got=%b exp=1111", q_bar); end
        cmp++; if (busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL rst_flags got=%b%b exp=00", busy, done); end
    endtask

    task automatic test_load_hold();
        load(4'b1010);
        cmp++; if (q_out !== 4'b1010) begin err++; $display("FAIL load_q got=%b exp=1010", q_out); end
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++; if (q_out !== 4'b1010) begin err++; $display("FAIL hold_q[%0d] got=%b exp=1010", i, q_out); end
        end
    endtask

    task automatic test_shift();
        load(4'b1011);
        mode = 2'b01; rot = 0; sin_r = 0; tick(); mode = 2'b00;
        cmp++; if (q_out !== 4'b0101) begin err++; $display("FAIL shr_q got=%b exp=0101", q_out); end
        cmp++; if (sout_r !== 1'b1 || sout_l !== 1'b0) begin err++; $display("FAIL shr_sout got=%b%b exp=01", sout_l, sout_r); end
        load(4'b1011);
        mode = 2'b01; rot = 1; tick(); mode = 2'b00; rot = 0;
        cmp++; if (q_out !== 4'b1101) begin err++; $display("FAIL ror_q got=%b exp=1101", q_out); end
        cmp++; if (sout_l !== 1'b1) begin err++; $display("FAIL ror_soutl got=%b exp=1", sout_l); end
    endtask

    task automatic test_burst();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'b0010; exp_q[1] = 4'b0100; exp_q[2] = 4'b1000;
        load(4'b0001);
        mode = 2'b10; shift_cnt = 3'd3; rot = 0; sin_l = 0; start = 1;
        tick(); start = 0;
        // mode/d_in changes are ignored while bursting
        mode = 2'b11; d_in = 4'b1111;
        cmp++; if (q_out !== 4'b0001 || busy !== 1'b1) begin err++; $display("FAIL burst_start got=%b/%b exp=0001/1", q_out, busy); end
        for (int i = 0; i < 3; i++) begin
            tick();
            cmp++; if (q_out !== exp_q[i]) begin err++; $display("FAIL burst_q[%0d] got=%b exp=%b", i, q_out, exp_q[i]); end
            cmp++; if (busy !== (i < 2) || done !== (i == 2)) begin err++; $display("FAIL burst_flags[%0d] got=%b%b exp=%b%b", i, busy, done, i < 2, i == 2); end
        end
        tick(); mode = 2'b00;
        cmp++; if (done !== 1'b0 || q_out !== 4'b1000) begin err++; $display("FAIL burst_after got=%b/%b exp=0/1000", done, q_out); end
    endtask

    task automatic test_burst_stall();
        int nbusy;
        bit seen;
        load(4'b0001);
        mode = 2'b10; shift_cnt = 3'd3; rot = 0; sin_l = 0; start = 1;
        tick(); start = 0; mode = 2'b00;
        nbusy = busy ? 1 : 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            en = (k == 1 || k == 2) ? 1'b0 : 1'b1;
            tick();
            if (busy) nbusy++;
            if (done) seen = 1;
            if (k == 2) begin
                cmp++; if (q_out !== 4'b0010 || busy !== 1'b1) begin err++; $display("FAIL stall_hold got=%b/%b exp=0010/1", q_out, busy); end
            end
        end
        en = 1;
        cmp++; if (!seen) begin err++; $display("FAIL stall_timeout got=no_done exp=done"); end
        cmp++; if (nbusy != 5) begin err++; $display("FAIL stall_busy_cycles got=%0d exp=5", nbusy); end
        cmp++; if (q_out !== 4'b1000) begin err++; $display("FAIL stall_final got=%b exp=1000", q_out); end
        tick();
        // preset aborts a burst without a done pulse
        load(4'b0001);
        mode = 2'b10; shift_cnt = 3'd5; start = 1;
        tick(); start = 0; mode = 2'b00;
        tick();
        preset = 1; tick(); preset = 0;
        cmp++; if (q_out !== 4'b1111 || busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL preset_abort got=%b/%b%b exp=1111/00", q_out, busy, done); end
        for (int i = 0; i < 2; i++) begin
            tick();
            cmp++; if (done !== 1'b0 || busy !== 1'b0) begin err++; $display("FAIL preset_nodone[%0d] got=%b%b exp=00", i, busy, done); end
        end
    endtask

    task automatic test_zero_count();
        load(4'b0110);
        mode = 2'b01; shift_cnt = 3'd0; start = 1;
        tick(); start = 0; en = 0;
        cmp++; if (q_out !== 4'b0110 || busy !== 1'b0 || done !== 1'b1) begin err++; $display("FAIL zero_start got=%b/%b%b exp=0110/01", q_out, busy, done); end
        tick(); en = 1; mode = 2'b00;
        cmp++; if (q_out !== 4'b0110 || busy !== 1'b0 || done !== 1'b0) begin err++; $display("FAIL zero_after got=%b/%b%b exp=0110/00", q_out, busy, done); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            clr       = ($urandom % 50) == 0;
            preset    = ($urandom % 40) == 0;
            en        = ($urandom % 4) != 0;
            mode      = 2'($urandom);
            rot       = 1'($urandom);
            sin_r     = 1'($urandom);
            sin_l     = 1'($urandom);
            d_in      = 4'($urandom);
            start     = ($urandom % 5) == 0;
            shift_cnt = 3'($urandom);
            tick();
            cmp++;
            if (q_out !== 4'(m_q) || q_bar !== ~4'(m_q) || sout_r !== 1'(m_q % 2) ||
                sout_l !== 1'(m_q / 8) || busy !== m_bursting || done !== m_done ||
                (busy && done)) begin
                err++;
                $display("FAIL rand[%0d] got q=%b busy=%b done=%b exp q=%b busy=%b done=%b",
                         i, q_out, busy, done, 4'(m_q), m_bursting, m_done);
            end
        end
        clr = 0; preset = 0; start = 0;
    endtask

    initial begin
        test_reset();
        test_load_hold();
        test_shift();
        test_burst();
        test_burst_stall();
        test_zero_count();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
`default_nettype wire
